// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths, index type and write-source enum
package regfile_pkg;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int REG_AW = $clog2(NREGS);
    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0] xlen_t;
    typedef enum logic [1:0] {WB_SRC_NONE, WB_SRC_PIPE, WB_SRC_EXT} wb_src_e;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: pipeline WB, long-latency handshake, scoreboard and register-file write bundle
interface regfile_wb_arbiter_if;
    logic               pipe_we;
    regfile_pkg::reg_idx_t pipe_rd;
    regfile_pkg::xlen_t    pipe_data;
    logic               ext_valid;
    logic               ext_ready;
    regfile_pkg::reg_idx_t ext_rd;
    regfile_pkg::xlen_t    ext_data;
    logic               issue_valid;
    regfile_pkg::reg_idx_t issue_rd;
    regfile_pkg::reg_idx_t rs1;
    regfile_pkg::reg_idx_t rs2;
    logic               busy_rs1;
    logic               busy_rs2;
    logic               wb_stall;
    logic               rf_we;
    regfile_pkg::reg_idx_t rf_rd;
    regfile_pkg::xlen_t    rf_data;
    modport master (
        output pipe_we, pipe_rd, pipe_data, ext_valid, ext_rd, ext_data, issue_valid, issue_rd, rs1, rs2,
        input  ext_ready, busy_rs1, busy_rs2, wb_stall, rf_we, rf_rd, rf_data
    );
    modport slave (
        input  pipe_we, pipe_rd, pipe_data, ext_valid, ext_rd, ext_data, issue_valid, issue_rd, rs1, rs2,
        output ext_ready, busy_rs1, busy_rs2, wb_stall, rf_we, rf_rd, rf_data
    );
endinterface

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-destination bits owed by the long-latency unit, with two read ports
module wb_scoreboard import regfile_pkg::*; (
    input  logic     clk,
    input  logic     rst,
    input  logic     set_en,
    input  reg_idx_t set_rd,
    input  logic     clr_en,
    input  reg_idx_t clr_rd,
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    output logic     busy_rs1,
    output logic     busy_rs2
);
    logic [NREGS-1:0] pend, set_mask, clr_mask;
    assign set_mask = (set_en && set_rd != '0) ? NREGS'(1) << set_rd : '0;
    assign clr_mask = clr_en ? NREGS'(1) << clr_rd : '0;
    // set is OR-ed after the clear so a same-cycle reissue keeps the bit
    always_ff @(posedge clk) begin
        if (rst) pend <= '0;
        else pend <= (pend & ~clr_mask) | set_mask;
    end
    assign busy_rs1 = pend[rs1] && rs1 != '0;
    assign busy_rs2 = pend[rs2] && rs2 != '0;
    a_no_waw: assert property (@(posedge clk) disable iff (rst)
        (set_en && set_rd != '0) |-> (!pend[set_rd] || (clr_en && clr_rd == set_rd)));
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between pipeline WB (priority) and a long-latency unit.
// Define WB_ARB_SCOREBOARD_EN to track pending long-latency destinations for the hazard unit.
module regfile_wb_arbiter import regfile_pkg::*; #(
    parameter int MAX_WAIT = 4
) (
    input logic clk,
    input logic rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] wait_cnt;
    logic stall, pipe_req, ext_ready, refused, hs, sb_busy1, sb_busy2;
    wb_src_e src;
    assign pipe_req = bus.pipe_we && bus.pipe_rd != '0;
    assign ext_ready = !rst && (stall || !pipe_req);
    assign refused = bus.ext_valid && !ext_ready;
    assign hs = bus.ext_valid && ext_ready;
    always_comb begin
        src = rst ? WB_SRC_NONE : (!stall && pipe_req) ? WB_SRC_PIPE : bus.ext_valid ? WB_SRC_EXT : WB_SRC_NONE;
    end
    assign bus.ext_ready = ext_ready;
    assign bus.rf_we = src == WB_SRC_PIPE || (src == WB_SRC_EXT && bus.ext_rd != '0);
    assign bus.rf_rd = src == WB_SRC_PIPE ? bus.pipe_rd : src == WB_SRC_EXT ? bus.ext_rd : '0;
    assign bus.rf_data = src == WB_SRC_PIPE ? bus.pipe_data : src == WB_SRC_EXT ? bus.ext_data : '0;
    assign bus.wb_stall = stall;
    // stall rises once the ext source has been refused MAX_WAIT times and drops with its handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            stall <= 1'b0;
        end else begin
            wait_cnt <= refused ? (wait_cnt == CW'(MAX_WAIT) ? wait_cnt : wait_cnt + 1'b1) : '0;
            stall <= hs ? 1'b0 : (refused && wait_cnt == CW'(MAX_WAIT - 1)) ? 1'b1 : stall;
        end
    end
    a_ext_hold: assert property (@(posedge clk) disable iff (rst)
        refused |=> (!bus.ext_valid || ($stable(bus.ext_rd) && $stable(bus.ext_data))));
`ifdef WB_ARB_SCOREBOARD_EN
    wb_scoreboard u_sb (
        .clk(clk),
        .rst(rst),
        .set_en(bus.issue_valid),
        .set_rd(bus.issue_rd),
        .clr_en(hs),
        .clr_rd(bus.ext_rd),
        .rs1(bus.rs1),
        .rs2(bus.rs2),
        .busy_rs1(sb_busy1),
        .busy_rs2(sb_busy2)
    );
`else
    logic unused_sb;
    assign unused_sb = ^{bus.issue_valid, bus.issue_rd, bus.rs1, bus.rs2};
    assign sb_busy1 = 1'b0;
    assign sb_busy2 = 1'b0;
`endif
    assign bus.busy_rs1 = !rst && sb_busy1;
    assign bus.busy_rs2 = !rst && sb_busy2;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scenario tasks plus a write scoreboard fed from a register-file model
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;
    typedef struct packed {reg_idx_t rd; xlen_t data;} wr_t;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int passed = 0;
    wr_t exp_q[$];
    xlen_t rf[NREGS];
    always #5 clk = ~clk;
    regfile_wb_arbiter_if bus();
    regfile_wb_arbiter #(.MAX_WAIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    initial for (int i = 0; i < NREGS; i++) rf[i] = '0;
    always @(posedge clk) if (!rst && bus.rf_we) rf[bus.rf_rd] <= bus.rf_data;
    always @(negedge clk) begin : monitor
        wr_t e;
        if (!rst && bus.rf_we) begin
            checks++;
            if (exp_q.size() == 0) $display("FAIL unexpected_write rd=%0d data=%h", bus.rf_rd, bus.rf_data);
            else begin
                e = exp_q.pop_front();
                if ({bus.rf_rd, bus.rf_data} !== e) $display("FAIL write got rd=%0d data=%h want rd=%0d data=%h", bus.rf_rd, bus.rf_data, e.rd, e.data);
                else passed++;
            end
        end
    end
    task automatic idle();
        bus.pipe_we = 0; bus.pipe_rd = '0; bus.pipe_data = '0;
        bus.ext_valid = 0; bus.ext_rd = '0; bus.ext_data = '0;
        bus.issue_valid = 0; bus.issue_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        idle();
        rst = 1;
        bus.pipe_we = 1; bus.pipe_rd = 4; bus.pipe_data = 32'h44444444;
        bus.ext_valid = 1; bus.ext_rd = 6; bus.ext_data = 32'h66666666;
        bus.rs1 = 4; bus.rs2 = 6;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.rf_we, bus.ext_ready, bus.busy_rs1, bus.busy_rs2} !== 4'b0) $display("FAIL reset_ctrl cyc%0d got we/rdy/b1/b2=%b want 0000", c, {bus.rf_we, bus.ext_ready, bus.busy_rs1, bus.busy_rs2});
            else passed++;
            checks++;
            if (bus.rf_rd !== '0 || bus.rf_data !== '0) $display("FAIL reset_port cyc%0d got rd=%0d data=%h want 0", c, bus.rf_rd, bus.rf_data);
            else passed++;
            tick();
        end
        checks++;
        if (bus.wb_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", bus.wb_stall);
        else passed++;
        idle();
        rst = 0;
        tick();
    endtask
    task automatic test_pipe_only();
        bus.pipe_we = 1; bus.pipe_rd = 1; bus.pipe_data = 32'hDEADBEEF;
        exp_q.push_back('{rd: 5'd1, data: 32'hDEADBEEF});
        @(negedge clk);
        checks++;
        if ({bus.rf_we, bus.rf_rd, bus.rf_data} !== {1'b1, 5'd1, 32'hDEADBEEF}) $display("FAIL pipe_port got we=%b rd=%0d data=%h want 1/1/deadbeef", bus.rf_we, bus.rf_rd, bus.rf_data);
        else passed++;
        tick();
        idle();
        checks++;
        if (rf[1] !== 32'hDEADBEEF) $display("FAIL pipe_readback got %h want deadbeef", rf[1]);
        else passed++;
    endtask
    task automatic test_collision();
        bus.pipe_we = 1; bus.pipe_rd = 2; bus.pipe_data = 32'h11111111;
        bus.ext_valid = 1; bus.ext_rd = 3; bus.ext_data = 32'h22222222;
        exp_q.push_back('{rd: 5'd2, data: 32'h11111111});
        exp_q.push_back('{rd: 5'd3, data: 32'h22222222});
        @(negedge clk);
        checks++;
        if (bus.ext_ready !== 1'b0 || bus.rf_rd !== 5'd2) $display("FAIL collision_pipe got rdy=%b rd=%0d want 0/2", bus.ext_ready, bus.rf_rd);
        else passed++;
        tick();
        bus.pipe_we = 0;
        @(negedge clk);
        checks++;
        if (bus.ext_ready !== 1'b1 || bus.rf_rd !== 5'd3) $display("FAIL collision_ext got rdy=%b rd=%0d want 1/3", bus.ext_ready, bus.rf_rd);
        else passed++;
        tick();
        idle();
        checks++;
        if (rf[3] !== 32'h22222222 || rf[2] !== 32'h11111111) $display("FAIL collision_rf got r2=%h r3=%h want 11111111/22222222", rf[2], rf[3]);
        else passed++;
    endtask
    task automatic test_starvation();
        for (int c = 0; c < 4; c++) exp_q.push_back('{rd: reg_idx_t'(10 + c), data: 32'hA000_0000 + c});
        exp_q.push_back('{rd: 5'd9, data: 32'hCAFE0009});
        exp_q.push_back('{rd: 5'd14, data: 32'hA000_0004});
        for (int c = 0; c < 6; c++) begin
            bus.pipe_we = 1;
            bus.pipe_rd = reg_idx_t'(c < 4 ? 10 + c : 14);
            bus.pipe_data = 32'hA000_0000 + (c < 4 ? c : 4);
            bus.ext_valid = c < 5; bus.ext_rd = 9; bus.ext_data = 32'hCAFE0009;
            @(negedge clk);
            checks++;
            if (c < 5 && bus.ext_ready !== (c == 4)) $display("FAIL starve_ready cyc%0d got %b want %b", c, bus.ext_ready, c == 4);
            else passed++;
            checks++;
            if (bus.wb_stall !== (c == 4)) $display("FAIL starve_stall cyc%0d got %b want %b", c, bus.wb_stall, c == 4);
            else passed++;
            tick();
        end
        idle();
        checks++;
        if (rf[14] !== 32'hA000_0004 || rf[9] !== 32'hCAFE0009) $display("FAIL starve_rf got r14=%h r9=%h want a0000004/cafe0009", rf[14], rf[9]);
        else passed++;
    endtask
    task automatic test_x0();
        bus.pipe_we = 1; bus.pipe_rd = 0; bus.pipe_data = 32'hFFFFFFFF;
        bus.ext_valid = 1; bus.ext_rd = 5; bus.ext_data = 32'h55555555;
        exp_q.push_back('{rd: 5'd5, data: 32'h55555555});
        @(negedge clk);
        checks++;
        if ({bus.ext_ready, bus.rf_we, bus.rf_rd} !== {1'b1, 1'b1, 5'd5}) $display("FAIL x0_pipe got rdy=%b we=%b rd=%0d want 1/1/5", bus.ext_ready, bus.rf_we, bus.rf_rd);
        else passed++;
        tick();
        bus.pipe_we = 0; bus.ext_rd = 0; bus.ext_data = 32'h0BAD0000;
        @(negedge clk);
        checks++;
        if (bus.ext_ready !== 1'b1 || bus.rf_we !== 1'b0) $display("FAIL x0_ext got rdy=%b we=%b want 1/0", bus.ext_ready, bus.rf_we);
        else passed++;
        tick();
        idle();
        checks++;
        if (rf[0] !== '0 || rf[5] !== 32'h55555555) $display("FAIL x0_rf got r0=%h r5=%h want 0/55555555", rf[0], rf[5]);
        else passed++;
    endtask
    task automatic test_scoreboard();
`ifdef WB_ARB_SCOREBOARD_EN
        logic exp_b[6] = '{0, 1, 1, 1, 1, 0};
        for (int c = 0; c < 6; c++) begin
            bus.rs1 = 7; bus.rs2 = 8;
            bus.issue_valid = c == 0 || c == 2; bus.issue_rd = 7;
            bus.ext_valid = c == 2 || c == 4; bus.ext_rd = 7;
            bus.ext_data = c == 2 ? 32'h77777777 : 32'h77770007;
            if (c == 2 || c == 4) exp_q.push_back('{rd: 5'd7, data: bus.ext_data});
            @(negedge clk);
            checks++;
            if (bus.busy_rs1 !== exp_b[c] || bus.busy_rs2 !== 1'b0) $display("FAIL sb_busy cyc%0d got b1=%b b2=%b want %b/0", c, bus.busy_rs1, bus.busy_rs2, exp_b[c]);
            else passed++;
            tick();
        end
`else
        for (int c = 0; c < 3; c++) begin
            bus.rs1 = 7; bus.rs2 = 7; bus.issue_valid = 1; bus.issue_rd = 7;
            @(negedge clk);
            checks++;
            if (bus.busy_rs1 !== 1'b0 || bus.busy_rs2 !== 1'b0) $display("FAIL sb_off cyc%0d got b1=%b b2=%b want 0/0", c, bus.busy_rs1, bus.busy_rs2);
            else passed++;
            tick();
        end
`endif
        idle();
    endtask
    initial begin
        idle();
        rst = 1;
        tick();
        test_reset();
        test_pipe_only();
        test_collision();
        test_starvation();
        test_x0();
        test_scoreboard();
        tick();
        checks++;
        if (exp_q.size() != 0) $display("FAIL missing_writes got %0d pending want 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
